// File: rtl/decstage.sv
// Decode stage: instruction register, 32x32 register file with write-through
// bypass, immediate extender and registered Immed/RF_A/RF_B outputs.
module decstage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        IR_lden,
  input  logic        Dec_lden,
  input  logic        RF_WrEn,
  input  logic        RF_B_sel,
  input  logic        RF_WrData_sel,
  input  logic [1:0]  ImmExt_sel,
  input  logic [31:0] ALU_out,
  input  logic [31:0] MEM_out,
  output logic [31:0] Immed,
  output logic [31:0] RF_A,
  output logic [31:0] RF_B
);

  logic [31:0] ir_q, ir_d;
  logic [31:0] immed_q, immed_d;
  logic [31:0] rf_a_q, rf_a_d;
  logic [31:0] rf_b_q, rf_b_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic [4:0]  rs_addr;
  logic [4:0]  rd_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  b_addr;
  logic [15:0] imm;
  logic [5:0]  opcode_unused;
  logic [31:0] wr_data;
  logic        wr_en_eff;
  logic [31:0] imm_ext;
  logic [31:0] read_a;
  logic [31:0] read_b;

  // All decode fields come from the held IR, never from the raw instr bus.
  assign rs_addr       = ir_q[25:21];
  assign rd_addr       = ir_q[20:16];
  assign rt_addr       = ir_q[15:11];
  assign imm           = ir_q[15:0];
  assign opcode_unused = ir_q[31:26];
  assign b_addr        = RF_B_sel ? rd_addr : rt_addr;

  assign wr_data   = RF_WrData_sel ? MEM_out : ALU_out;
  assign wr_en_eff = RF_WrEn && (rd_addr != 5'd0);

  always_comb begin
    imm_ext = 32'h0000_0000;
    case (ImmExt_sel)
      2'b00:   imm_ext = {16'h0000, imm};
      2'b01:   imm_ext = {{16{imm[15]}}, imm};
      2'b10:   imm_ext = {imm, 16'h0000};
      default: imm_ext = {{14{imm[15]}}, imm, 2'b00};
    endcase
  end

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (wr_en_eff) begin
      rf_d[rd_addr] = wr_data;
    end
  end

  // A same-edge write to the register being read is forwarded so the output
  // registers see the new value without an extra cycle.
  always_comb begin
    read_a = (rs_addr == 5'd0) ? 32'h0000_0000 : rf_q[rs_addr];
    if (wr_en_eff && (rd_addr == rs_addr)) begin
      read_a = wr_data;
    end
  end

  always_comb begin
    read_b = (b_addr == 5'd0) ? 32'h0000_0000 : rf_q[b_addr];
    if (wr_en_eff && (rd_addr == b_addr)) begin
      read_b = wr_data;
    end
  end

  always_comb begin
    ir_d    = IR_lden ? instr : ir_q;
    immed_d = Dec_lden ? imm_ext : immed_q;
    rf_a_d  = Dec_lden ? read_a : rf_a_q;
    rf_b_d  = Dec_lden ? read_b : rf_b_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q    <= 32'h0000_0000;
      immed_q <= 32'h0000_0000;
      rf_a_q  <= 32'h0000_0000;
      rf_b_q  <= 32'h0000_0000;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'h0000_0000;
      end
    end else begin
      ir_q    <= ir_d;
      immed_q <= immed_d;
      rf_a_q  <= rf_a_d;
      rf_b_q  <= rf_b_d;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign Immed = immed_q;
  assign RF_A  = rf_a_q;
  assign RF_B  = rf_b_q;

endmodule

// File: tb/tb_decstage.sv
// Directed bench for decstage: a vector table for the main function plus
// hand-written reset sequences.
module tb_decstage;

  localparam logic        H = 1'b1;
  localparam logic        L = 1'b0;
  localparam logic [31:0] Z = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        IR_lden, Dec_lden, RF_WrEn, RF_B_sel, RF_WrData_sel;
  logic [1:0]  ImmExt_sel;
  logic [31:0] ALU_out, MEM_out;
  logic [31:0] Immed, RF_A, RF_B;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decstage dut (
    .clk(clk), .reset(reset), .instr(instr),
    .IR_lden(IR_lden), .Dec_lden(Dec_lden), .RF_WrEn(RF_WrEn),
    .RF_B_sel(RF_B_sel), .RF_WrData_sel(RF_WrData_sel), .ImmExt_sel(ImmExt_sel),
    .ALU_out(ALU_out), .MEM_out(MEM_out),
    .Immed(Immed), .RF_A(RF_A), .RF_B(RF_B)
  );

  typedef struct {
    logic        irl, decl, wen, bsel, wsel;
    logic [1:0]  ext;
    logic [31:0] instr, alu, mem;
    logic [31:0] e_imm, e_a, e_b;
  } vec_t;

  vec_t vecs [28];

  function automatic vec_t v(input logic irl, decl, wen, bsel, wsel,
                             input logic [1:0] ext,
                             input logic [31:0] ins, alu, mem, ei, ea, eb);
    vec_t r;
    r.irl = irl; r.decl = decl; r.wen = wen; r.bsel = bsel; r.wsel = wsel;
    r.ext = ext; r.instr = ins; r.alu = alu; r.mem = mem;
    r.e_imm = ei; r.e_a = ea; r.e_b = eb;
    return r;
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] rs, rd, input logic [15:0] im);
    return {6'd0, rs, rd, im};
  endfunction

  task automatic check(input string name, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [31:0] ei, ea, eb);
    check({name, " Immed"}, Immed, ei);
    check({name, " RF_A"}, RF_A, ea);
    check({name, " RF_B"}, RF_B, eb);
    $display("%s: Immed=%h RF_A=%h RF_B=%h", name, Immed, RF_A, RF_B);
  endtask

  task automatic drive(input logic irl, decl, wen, bsel, wsel, input logic [1:0] ext,
                       input logic [31:0] ins, alu, mem);
    IR_lden = irl; Dec_lden = decl; RF_WrEn = wen; RF_B_sel = bsel;
    RF_WrData_sel = wsel; ImmExt_sel = ext; instr = ins; ALU_out = alu; MEM_out = mem;
  endtask

  task automatic idle();
    drive(L, L, L, L, L, 2'b00, Z, Z, Z);
  endtask

  initial begin
    vecs[0]  = v(H,L,L,L,L,2'b00, 32'h0C22FFFC, Z, Z, Z, Z, Z);
    vecs[1]  = v(L,H,L,L,L,2'b01, Z, Z, Z, 32'hFFFFFFFC, Z, Z);
    vecs[2]  = v(L,H,L,L,L,2'b00, Z, Z, Z, 32'h0000FFFC, Z, Z);
    vecs[3]  = v(L,H,L,L,L,2'b10, Z, Z, Z, 32'hFFFC0000, Z, Z);
    vecs[4]  = v(L,H,L,L,L,2'b11, Z, Z, Z, 32'hFFFFFFF0, Z, Z);
    vecs[5]  = v(H,L,L,L,L,2'b00, mk(5'd0,5'd5,16'h0), Z, Z, 32'hFFFFFFF0, Z, Z);
    vecs[6]  = v(H,L,H,L,L,2'b00, mk(5'd5,5'd0,16'h0), 32'hDEADBEEF, Z, 32'hFFFFFFF0, Z, Z);
    vecs[7]  = v(L,H,L,L,L,2'b00, Z, Z, Z, Z, 32'hDEADBEEF, Z);
    vecs[8]  = v(H,L,L,L,L,2'b00, mk(5'd0,5'd5,16'h0), Z, Z, Z, 32'hDEADBEEF, Z);
    vecs[9]  = v(H,L,H,L,H,2'b00, mk(5'd5,5'd0,16'h0), 32'h11111111, 32'h12345678, Z, 32'hDEADBEEF, Z);
    vecs[10] = v(L,H,L,L,L,2'b00, Z, Z, Z, Z, 32'h12345678, Z);
    vecs[11] = v(H,L,L,L,L,2'b00, mk(5'd0,5'd0,16'h0), Z, Z, Z, 32'h12345678, Z);
    vecs[12] = v(L,H,H,L,L,2'b00, Z, 32'hFFFFFFFF, Z, Z, Z, Z);
    vecs[13] = v(L,H,L,H,L,2'b00, Z, Z, Z, Z, Z, Z);
    vecs[14] = v(H,L,L,L,L,2'b00, mk(5'd0,5'd7,16'h0), Z, Z, Z, Z, Z);
    vecs[15] = v(L,H,H,H,L,2'b00, Z, 32'hA5A5A5A5, Z, Z, Z, 32'hA5A5A5A5);
    vecs[16] = v(H,L,L,L,L,2'b00, mk(5'd9,5'd9,16'h1234), Z, Z, Z, Z, 32'hA5A5A5A5);
    vecs[17] = v(L,H,H,H,L,2'b01, Z, 32'h0BADF00D, Z, 32'h00001234, 32'h0BADF00D, 32'h0BADF00D);
    vecs[18] = v(H,L,L,L,L,2'b00, mk(5'd7,5'd0,16'h0), Z, Z, 32'h00001234, 32'h0BADF00D, 32'h0BADF00D);
    vecs[19] = v(H,H,L,L,L,2'b01, mk(5'd5,5'd0,16'h4804), Z, Z, Z, 32'hA5A5A5A5, Z);
    vecs[20] = v(L,H,L,L,L,2'b01, Z, Z, Z, 32'h00004804, 32'h12345678, 32'h0BADF00D);
    vecs[21] = v(H,L,L,L,L,2'b00, mk(5'd0,5'd12,16'h0), Z, Z, 32'h00004804, 32'h12345678, 32'h0BADF00D);
    vecs[22] = v(H,H,H,H,L,2'b00, mk(5'd12,5'd20,16'h0), 32'h00C0FFEE, Z, Z, Z, 32'h00C0FFEE);
    vecs[23] = v(L,H,L,H,L,2'b00, Z, Z, Z, Z, 32'h00C0FFEE, Z);
    vecs[24] = v(H,L,L,L,L,2'b01, mk(5'd1,5'd2,16'hFFFF), Z, Z, Z, 32'h00C0FFEE, Z);
    vecs[25] = v(H,L,L,H,L,2'b10, mk(5'd9,5'd5,16'h1234), Z, Z, Z, 32'h00C0FFEE, Z);
    vecs[26] = v(H,L,L,L,L,2'b11, mk(5'd5,5'd9,16'h0), Z, Z, Z, 32'h00C0FFEE, Z);
    vecs[27] = v(L,H,L,H,L,2'b00, Z, Z, Z, Z, 32'h12345678, 32'h0BADF00D);

    // Reset held low across two edges with every load/write enable active.
    reset = 1'b0;
    idle();
    #1;
    check_outs("reset_initial", Z, Z, Z);
    drive(H, H, H, H, L, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    @(negedge clk);
    check_outs("reset_held", Z, Z, Z);
    idle();
    reset = 1'b1;

    for (int i = 0; i < 28; i++) begin
      drive(vecs[i].irl, vecs[i].decl, vecs[i].wen, vecs[i].bsel, vecs[i].wsel,
            vecs[i].ext, vecs[i].instr, vecs[i].alu, vecs[i].mem);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].e_imm, vecs[i].e_a, vecs[i].e_b);
    end

    // Fill r1..r31 with nonzero values, then reset asynchronously mid-cycle.
    for (int r = 1; r < 32; r++) begin
      drive(H, L, L, L, L, 2'b00, mk(r[4:0], r[4:0], 16'h0), Z, Z);
      @(negedge clk);
      drive(L, L, H, L, L, 2'b00, Z, 32'h01010101 * r, Z);
      @(negedge clk);
    end
    drive(H, L, L, L, L, 2'b00, mk(5'd3, 5'd4, 16'hFFFF), Z, Z);
    @(negedge clk);
    drive(L, H, L, H, L, 2'b01, Z, Z, Z);
    @(negedge clk);
    check_outs("fill_readback", 32'hFFFFFFFF, 32'h03030303, 32'h04040404);
    idle();
    #2;
    reset = 1'b0;
    #1;
    check_outs("async_reset_immediate", Z, Z, Z);
    drive(H, H, H, H, L, 2'b01, mk(5'd1, 5'd1, 16'hFFFF), 32'hFFFFFFFF, Z);
    @(negedge clk);
    check_outs("reset_suppress", Z, Z, Z);
    idle();
    reset = 1'b1;
    drive(L, H, L, H, L, 2'b01, Z, Z, Z);
    @(negedge clk);
    check_outs("ir_cleared", Z, Z, Z);
    for (int k = 1; k <= 32; k++) begin
      drive(H, H, L, H, L, 2'b00, mk(k[4:0], k[4:0], 16'h0), Z, Z);
      @(negedge clk);
      check($sformatf("reg_r%0d_after_reset A", k - 1), RF_A, Z);
      check($sformatf("reg_r%0d_after_reset B", k - 1), RF_B, Z);
      $display("scan r%0d: RF_A=%h RF_B=%h", k - 1, RF_A, RF_B);
    end

    // Reset asserted just before a write edge: r6 must end up 0, not old or new data.
    drive(H, L, L, L, L, 2'b00, mk(5'd0, 5'd6, 16'h0), Z, Z);
    @(negedge clk);
    drive(L, L, H, L, L, 2'b00, Z, 32'h66666666, Z);
    @(negedge clk);
    drive(H, L, L, L, L, 2'b00, mk(5'd6, 5'd6, 16'h0), Z, Z);
    @(negedge clk);
    drive(L, H, L, H, L, 2'b00, Z, Z, Z);
    @(negedge clk);
    check_outs("r6_written", Z, 32'h66666666, 32'h66666666);
    drive(L, H, H, H, L, 2'b00, Z, 32'h77777777, Z);
    #4;
    reset = 1'b0;
    @(negedge clk);
    check_outs("reset_on_write_edge", Z, Z, Z);
    idle();
    reset = 1'b1;
    drive(H, L, L, L, L, 2'b00, mk(5'd6, 5'd6, 16'h0), Z, Z);
    @(negedge clk);
    drive(L, H, L, H, L, 2'b00, Z, Z, Z);
    @(negedge clk);
    check_outs("r6_no_partial_write", Z, Z, Z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decstage.md
DECSTAGE -- requirements
Module: decstage

Interface
REQ-001 The block SHALL have no parameters; register count 32, data width 32.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low; reset=0 clears all state immediately, independent of clk.
REQ-004 instr  input  32  instruction word from the fetch stage memory output.
REQ-005 IR_lden  input  1  instruction register load enable.
REQ-006 Dec_lden  input  1  load enable for output registers Immed/RF_A/RF_B.
REQ-007 RF_WrEn  input  1  register file write enable.
REQ-008 RF_B_sel  input  1  0: port B reads IR[15:11]; 1: port B reads IR[20:16].
REQ-009 RF_WrData_sel  input  1  0: write data = ALU_out; 1: write data = MEM_out.
REQ-010 ImmExt_sel  input  2  immediate extension mode (REQ-016).
REQ-011 ALU_out  input  32  write-back data from the ALU stage.
REQ-012 MEM_out  input  32  write-back data from the memory stage.
REQ-013 Immed  output  32  registered extended immediate.
REQ-014 RF_A  output  32  registered read data, address IR[25:21].
REQ-015 RF_B  output  32  registered read data, address per RF_B_sel.

Function
REQ-016 ImmExt_sel SHALL give: 00 zero-extend IR[15:0]; 01 sign-extend IR[15:0]; 10 {IR[15:0],16'h0000}; 11 sign-extend IR[15:0] then shift left 2, upper bits discarded.
REQ-017 IR SHALL load instr on posedge clk when IR_lden=1 and hold otherwise.
REQ-018 Decode fields (rs=IR[25:21], rd=IR[20:16], rt=IR[15:11], imm=IR[15:0]) SHALL always come from IR, never directly from instr.
REQ-019 The register file SHALL hold 32x32-bit registers; register 0 SHALL read 0 always and ignore writes.
REQ-020 On posedge clk with RF_WrEn=1, register IR[20:16] SHALL be written with the value selected by RF_WrData_sel.
REQ-021 On posedge clk with Dec_lden=1, Immed, RF_A and RF_B SHALL capture the combinational extend/read results from the current IR; with Dec_lden=0 they hold.
REQ-022 Same-edge write and read of the same nonzero register with Dec_lden=1: RF_A/RF_B SHALL capture the new write data (write-through bypass).
REQ-023 Latency: instr -> IR 1 edge; IR -> Immed/RF_A/RF_B 1 further edge; write -> visible in register read 1 edge (0 with bypass).
REQ-024 IR_lden and Dec_lden asserted on the same edge: outputs SHALL reflect the OLD IR, and IR SHALL take the new instr.
REQ-025 IR_lden, Dec_lden and RF_WrEn asserted on the same edge: the write SHALL use the OLD IR[20:16] as its address.
REQ-026 No output SHALL be X after reset; all arithmetic SHALL be unsigned 32-bit wrap, with no overflow signalling.

Reset
REQ-027 With reset=0, IR, Immed, RF_A, RF_B and all 32 registers SHALL be 0 within the same time step, regardless of clk.
REQ-028 Writes and loads SHALL be suppressed while reset=0; the first capture occurs on the first posedge after reset rises.
REQ-029 reset asserted mid-operation, e.g. on a write edge, SHALL leave all state 0 with no partial write.

Verification
REQ-030 Reset, then instr=0x0C22FFFC, IR_lden=1, edge; ImmExt_sel=01, Dec_lden=1, edge -> Immed=0xFFFFFFFC; ImmExt_sel=00 -> 0x0000FFFC; 10 -> 0xFFFC0000; 11 -> 0xFFFFFFF0.
REQ-031 IR rd=5, RF_WrEn=1, RF_WrData_sel=0, ALU_out=0xDEADBEEF, edge; IR rs=5, Dec_lden edge -> RF_A=0xDEADBEEF; repeat with RF_WrData_sel=1, MEM_out=0x12345678 -> 0x12345678.
REQ-032 Write 0xFFFFFFFF to rd=0, then read rs=0 -> RF_A=0.
REQ-033 Same-edge write of 0xA5A5A5A5 to r7 while reading r7 on port B with RF_B_sel=1, Dec_lden=1 -> RF_B=0xA5A5A5A5 after that edge.
REQ-034 Load r1..r31 with nonzero values, pull reset low between edges -> all outputs and registers read 0 immediately and after release.
REQ-035 Dec_lden=0 with IR changing -> Immed/RF_A/RF_B unchanged across 3 edges.
